// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared RV32E control definitions: ALU opcodes, instruction opcodes, FSM states
// and the datapath mux encodings driven by the control FSM.
package rv32e_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PC_ALU          = 2'd0,
    PC_ALUOUT       = 2'd1,
    PC_ALUOUT_ALIGN = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    A_RS1   = 2'd0,
    A_PC    = 2'd1,
    A_OLDPC = 2'd2,
    A_ZERO  = 2'd3
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  // Arithmetic/logic op selected by funct3 for OP and OP-IMM.
  function automatic alu_op_e f3_alu_op(input logic [2:0] funct3, input logic funct7_5);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Shared memory handshake between the control FSM (master) and the memory port.
interface multi_cycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multi_cycle_ctrl_alu_decoder.sv
// Maps {opcode, funct3, funct7[5]} to the ALU operation, operand swap and legality.
module alu_decoder
  import rv32e_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op,
  output logic       alu_swap,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_swap = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OPC_OP: begin
        alu_op = f3_alu_op(funct3, funct7_5);
        legal  = !funct7_5 || (funct3 == 3'b000) || (funct3 == 3'b101);
        // The ALU computes in2 - in1, so subtraction exchanges the operands.
        if (funct3 == 3'b000 && funct7_5) begin
          alu_op   = ALU_SUB;
          alu_swap = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_op = f3_alu_op(funct3, funct7_5);
        legal  = !(funct3 == 3'b001 && funct7_5);
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: begin
            alu_op   = ALU_SUB;
            alu_swap = 1'b1;
          end
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        legal  = 1'b0;
        endcase
      end
      OPC_LUI, OPC_AUIPC, OPC_JALR: alu_op = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32E core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath enables and mux selects.
module multi_cycle_ctrl
  import rv32e_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] instr,
  input  logic                 alu_zero,
  input  logic                 alu_lsb,
  multi_cycle_ctrl_if.master   mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic                 alu_swap,
  output logic [3:0]           alu_op,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  state_e     state_q, state_d;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  alu_op_e    dec_op;
  logic       dec_swap, dec_legal;
  logic       uses_rd, uses_rs1, uses_rs2, regs_bad, shift_bad, taken;
  logic       mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, reg_we_c, swap_c;
  pc_src_e    pc_src_c;
  a_sel_e     a_sel_c;
  b_sel_e     b_sel_c;
  wb_sel_e    wb_sel_c;
  alu_op_e    op_c;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[10:7], instr[18:15], instr[23:20]};

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alu_op   (dec_op),
    .alu_swap (dec_swap),
    .legal    (dec_legal)
  );

  // RV32E has 16 registers: any used register field with bit 4 set is illegal.
  assign uses_rd  = opcode inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_JAL, OPC_JALR};
  assign uses_rs1 = opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  assign uses_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign regs_bad = (uses_rd && instr[11]) || (uses_rs1 && instr[19]) || (uses_rs2 && instr[24]);

  assign shift_bad = (opcode == OPC_OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101)
                     && (instr[31] || (|instr[29:25]));

  assign taken = funct3[2] ? (alu_lsb ^ funct3[0]) : (alu_zero ^ funct3[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    swap_c     = 1'b0;
    pc_src_c   = PC_ALU;
    a_sel_c    = A_RS1;
    b_sel_c    = B_RS2;
    wb_sel_c   = WB_ALUOUT;
    op_c       = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        a_sel_c   = A_PC;
        b_sel_c   = B_FOUR;
        if (mem.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_sel_c = A_OLDPC;
        b_sel_c = B_IMM;
        case (opcode)
          OPC_OP:                                      state_d = S_EXEC_R;
          OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JALR:    state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE:                         state_d = S_MEM_ADDR;
          OPC_BRANCH:                                  state_d = S_BRANCH;
          OPC_JAL:                                     state_d = S_JUMP;
          default:                                     state_d = S_TRAP;
        endcase
        if (regs_bad) state_d = S_TRAP;
      end
      S_EXEC_R: begin
        op_c    = dec_op;
        swap_c  = dec_swap;
        state_d = dec_legal ? S_WB_ALU : S_TRAP;
      end
      S_EXEC_I: begin
        b_sel_c = B_IMM;
        case (opcode)
          OPC_OP_IMM: op_c    = dec_op;
          OPC_LUI:    a_sel_c = A_ZERO;
          OPC_AUIPC:  a_sel_c = A_OLDPC;
          default:    a_sel_c = A_RS1;
        endcase
        state_d = (opcode == OPC_JALR) ? S_JUMP : S_WB_ALU;
        if (!dec_legal || shift_bad) state_d = S_TRAP;
      end
      S_MEM_ADDR: begin
        b_sel_c = B_IMM;
        state_d = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_we_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we_c = 1'b1;
        wb_sel_c = WB_MDR;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        op_c   = dec_op;
        swap_c = dec_swap;
        if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          pc_we_c  = taken;
          pc_src_c = PC_ALUOUT;
          state_d  = S_FETCH;
        end
      end
      S_JUMP: begin
        reg_we_c = 1'b1;
        wb_sel_c = WB_PC;
        pc_we_c  = 1'b1;
        pc_src_c = (opcode == OPC_JALR) ? PC_ALUOUT_ALIGN : PC_ALUOUT;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // State resets to FETCH, so enables are gated to stay quiet while reset is held.
  assign mem.mem_req  = rst_n & mem_req_c;
  assign mem.mem_we   = rst_n & mem_we_c;
  assign mem.addr_sel = addr_sel_c;
  assign ir_we        = rst_n & ir_we_c;
  assign pc_we        = rst_n & pc_we_c;
  assign reg_we       = rst_n & reg_we_c;
  assign pc_src       = pc_src_c;
  assign alu_a_sel    = a_sel_c;
  assign alu_b_sel    = b_sel_c;
  assign alu_swap     = swap_c;
  assign alu_op       = op_c;
  assign wb_sel       = wb_sel_c;
  assign illegal      = illegal_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-instruction state sequences and outputs.
module tb_multi_cycle_ctrl;
  import rv32e_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        alu_lsb = 1'b0;
  logic        ir_we, pc_we, alu_swap, reg_we, illegal;
  logic [1:0]  pc_src, alu_a_sel, alu_b_sel, wb_sel;
  logic [3:0]  alu_op, state_o;
  int          checks = 0;
  int          errors = 0;

  multi_cycle_ctrl_if mif ();

  multi_cycle_ctrl #(.BIT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .alu_lsb   (alu_lsb),
    .mem       (mif),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_swap  (alu_swap),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete a zero-wait fetch, load the new instruction and land in DECODE.
  task automatic fetch_then(input string tag, input logic [31:0] ins);
    mif.mem_ready = 1'b1;
    #1;
    chk({tag, " fetch st"}, state_o, S_FETCH);
    chk({tag, " fetch ir_we"}, ir_we, 1'b1);
    chk({tag, " fetch pc_we"}, pc_we, 1'b1);
    step();
    instr = ins;
    #1;
    chk({tag, " decode st"}, state_o, S_DECODE);
    chk({tag, " decode mem_req"}, mif.mem_req, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst st", state_o, S_FETCH);
    chk("rst illegal", illegal, 1'b0);
    chk("rst mem_req", mif.mem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset st", state_o, S_FETCH);
    chk("reset mem_req", mif.mem_req, 1'b0);
    chk("reset pc_we", pc_we, 1'b0);
    chk("reset illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset mem_req", mif.mem_req, 1'b1);
    chk("post-reset addr_sel", mif.addr_sel, 1'b0);
    chk("fetch a_sel", alu_a_sel, 2'd1);
    chk("fetch b_sel", alu_b_sel, 2'd2);
    chk("fetch pc_src", pc_src, 2'd0);

    // ADD x3,x1,x2
    fetch_then("add", 32'h002081B3);
    chk("add decode a_sel", alu_a_sel, 2'd2);
    chk("add decode b_sel", alu_b_sel, 2'd1);
    step(); #1;
    chk("add exec st", state_o, S_EXEC_R);
    chk("add exec op", alu_op, 4'd0);
    chk("add exec swap", alu_swap, 1'b0);
    chk("add exec reg_we", reg_we, 1'b0);
    step(); #1;
    chk("add wb st", state_o, S_WB_ALU);
    chk("add wb reg_we", reg_we, 1'b1);
    chk("add wb sel", wb_sel, 2'd0);
    step(); #1;
    chk("add done st", state_o, S_FETCH);
    chk("add done reg_we", reg_we, 1'b0);

    // SUB x3,x1,x2
    fetch_then("sub", 32'h402081B3);
    step(); #1;
    chk("sub exec op", alu_op, 4'd1);
    chk("sub exec swap", alu_swap, 1'b1);
    step(); step(); #1;
    chk("sub done st", state_o, S_FETCH);

    // LW x5,4(x1) with three wait cycles in MEM_RD; ready in DECODE/MEM_ADDR ignored
    fetch_then("lw", 32'h00412283);
    step(); #1;
    chk("lw addr st", state_o, S_MEM_ADDR);
    chk("lw addr mem_req", mif.mem_req, 1'b0);
    chk("lw addr b_sel", alu_b_sel, 2'd1);
    step();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mif.mem_ready = 1'b1;
      #1;
      chk("lw rd st", state_o, S_MEM_RD);
      chk("lw rd mem_req", mif.mem_req, 1'b1);
      chk("lw rd addr_sel", mif.addr_sel, 1'b1);
      chk("lw rd mem_we", mif.mem_we, 1'b0);
      step();
    end
    #1;
    chk("lw wb st", state_o, S_WB_MEM);
    chk("lw wb reg_we", reg_we, 1'b1);
    chk("lw wb sel", wb_sel, 2'd1);
    step(); #1;
    chk("lw done st", state_o, S_FETCH);

    // SW x2,0(x1)
    fetch_then("sw", 32'h0020A023);
    step(); step(); #1;
    chk("sw wr st", state_o, S_MEM_WR);
    chk("sw wr mem_we", mif.mem_we, 1'b1);
    chk("sw wr addr_sel", mif.addr_sel, 1'b1);
    step(); #1;
    chk("sw done st", state_o, S_FETCH);

    // BLT taken, BGE not taken, BEQ taken
    fetch_then("blt", 32'h0020C463);
    step();
    alu_lsb = 1'b1;
    #1;
    chk("blt st", state_o, S_BRANCH);
    chk("blt op", alu_op, 4'd2);
    chk("blt swap", alu_swap, 1'b0);
    chk("blt pc_we", pc_we, 1'b1);
    chk("blt pc_src", pc_src, 2'd1);
    step(); #1;
    chk("blt done st", state_o, S_FETCH);
    fetch_then("bge", 32'h0020D463);
    step(); #1;
    chk("bge op", alu_op, 4'd2);
    chk("bge pc_we", pc_we, 1'b0);
    alu_lsb = 1'b0;
    step();
    fetch_then("beq", 32'h00208463);
    step();
    alu_zero = 1'b1;
    #1;
    chk("beq op", alu_op, 4'd1);
    chk("beq pc_we", pc_we, 1'b1);
    step();
    alu_zero = 1'b0;

    // JAL x1,8 and JALR x1,0(x2)
    fetch_then("jal", 32'h008000EF);
    step(); #1;
    chk("jal st", state_o, S_JUMP);
    chk("jal reg_we", reg_we, 1'b1);
    chk("jal wb_sel", wb_sel, 2'd2);
    chk("jal pc_we", pc_we, 1'b1);
    chk("jal pc_src", pc_src, 2'd1);
    step();
    fetch_then("jalr", 32'h000100E7);
    step(); #1;
    chk("jalr exec st", state_o, S_EXEC_I);
    chk("jalr exec a_sel", alu_a_sel, 2'd0);
    chk("jalr exec b_sel", alu_b_sel, 2'd1);
    step(); #1;
    chk("jalr jump st", state_o, S_JUMP);
    chk("jalr pc_src", pc_src, 2'd2);
    step();

    // SRAI, LUI, ADDI
    fetch_then("srai", 32'h4030D093);
    step(); #1;
    chk("srai op", alu_op, 4'd9);
    step(); #1;
    chk("srai wb st", state_o, S_WB_ALU);
    step();
    fetch_then("lui", 32'h000010B7);
    step(); #1;
    chk("lui a_sel", alu_a_sel, 2'd3);
    chk("lui op", alu_op, 4'd0);
    step(); step();
    fetch_then("addi", 32'h00F00093);
    step(); #1;
    chk("addi exec st", state_o, S_EXEC_I);
    step(); #1;
    chk("addi wb reg_we", reg_we, 1'b1);
    step();

    // ADDI with rd=x17 traps until reset
    fetch_then("addi17", 32'h00F00893);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("trap st", state_o, S_TRAP);
      chk("trap illegal", illegal, 1'b1);
      chk("trap reg_we", reg_we, 1'b0);
      chk("trap mem_req", mif.mem_req, 1'b0);
    end
    do_reset();

    // SLLI with funct7=0x20 traps from EXEC_I
    fetch_then("slli bad", 32'h40309093);
    step(); step(); #1;
    chk("slli bad st", state_o, S_TRAP);
    do_reset();

    // Branch funct3=010 traps without a PC write
    fetch_then("br bad", 32'h0020A463);
    alu_zero = 1'b1;
    step(); #1;
    chk("br bad pc_we", pc_we, 1'b0);
    step(); #1;
    chk("br bad st", state_o, S_TRAP);
    alu_zero = 1'b0;
    do_reset();

    // Reset during a fetch wait abandons the access
    mif.mem_ready = 1'b0;
    #1;
    chk("fw mem_req", mif.mem_req, 1'b1);
    step(); #1;
    chk("fw hold mem_req", mif.mem_req, 1'b1);
    chk("fw hold pc_we", pc_we, 1'b0);
    rst_n = 1'b0;
    mif.mem_ready = 1'b1;
    #1;
    chk("fw rst mem_req", mif.mem_req, 1'b0);
    chk("fw rst pc_we", pc_we, 1'b0);
    chk("fw rst ir_we", ir_we, 1'b0);
    chk("fw rst st", state_o, S_FETCH);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fw resume mem_req", mif.mem_req, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
